// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg
// Shared widths, reset PC, fetch FSM states and the fetch-entry record.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo
// DEPTH-entry FIFO of fetch entries with synchronous clear; head is registered.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // Push into a full FIFO is only legal when the head leaves in the same cycle
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/cpu_fetch_queue.sv
// ============================================================================
// cpu_fetch_queue
// Instruction fetch stage: issues imem reads, buffers responses, drops stale ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WIDTH-1:0]  imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  output logic [WIDTH-1:0]  dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [OUT_W-1:0]  live_out;
  logic [OUT_W-1:0]  stale_cnt;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              accept;
  logic              rsp_ok;
  logic              discard;
  logic              push;
  logic              pop;

  // Slots already claimed by live in-flight reads count against FIFO space
  assign live_out  = outstanding_q - drop_cnt_q;
  assign imem_req  = rst && !redirect
                  && (outstanding_q < OUT_W'(MAX_OUT))
                  && ((SUM_W'(fifo_count) + SUM_W'(live_out)) < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign push_entry = '{instr: imem_rdata, pc: resp_pc_q};
  assign pop        = dec_valid && dec_ready && !redirect;

  always_comb begin
    accept        = imem_req && imem_ready;
    rsp_ok        = imem_rvalid && (outstanding_q != '0);
    stale_cnt     = outstanding_q - (rsp_ok ? OUT_W'(1) : OUT_W'(0));
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q;
    push          = 1'b0;
    if (accept && !rsp_ok) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!accept && rsp_ok) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
    // A response landing in the redirect cycle is stale and already excluded from stale_cnt
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = stale_cnt;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      if (rsp_ok) begin
        if (discard) begin
          drop_cnt_d = drop_cnt_q - OUT_W'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (redirect && (stale_cnt != '0)) state_d = FLUSH;
      FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    discard = (state_q == FLUSH) && (drop_cnt_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign dec_valid = (fifo_count != '0);
  assign dec_instr = fifo_head.instr;
  assign dec_pc    = fifo_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch_queue.sv
// ============================================================================
// tb_cpu_fetch_queue
// Directed per-cycle vectors against cpu_fetch_queue with an in-order imem model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_fetch_queue;
  import cpu_pkg::*;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [WIDTH-1:0]  imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic [WIDTH-1:0]  dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;

  typedef struct {
    int seg;
    bit rdy;
    bit redir;
    int rpc;
    bit req;
    int addr;
    bit v;
    int pc;
    int ins;
  } vec_t;

  typedef struct {
    int addr;
    int due;
  } pend_t;

  vec_t  vecs[$];
  pend_t pend[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    lat      = 1;
  int    mout     = 0;

  cpu_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " dec_valid"}, 32'(dec_valid), 32'd0);
    chk({tag, " dec_instr"}, 32'(dec_instr), 32'd0);
    chk({tag, " dec_pc"},    32'(dec_pc),    32'd0);
    chk({tag, " imem_req"},  32'(imem_req),  32'd0);
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
  endtask

  // In-order memory: a read accepted at the end of cycle c answers in cycle c+lat
  task automatic tick();
    bit acc;
    int a;
    acc = imem_req && imem_ready;
    a   = int'(imem_addr);
    @(posedge clk);
    cyc++;
    if (acc) begin
      pend.push_back('{addr: a, due: cyc + lat - 1});
      mout++;
    end
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      assert (mout > 0) else $error("imem_rvalid driven with nothing outstanding");
      imem_rvalid = 1'b1;
      imem_rdata  = WIDTH'(100 + pend[0].addr);
      pend.delete(0);
      mout--;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic add(input int seg, input bit rdy, input bit redir, input int rpc,
                     input bit req, input int addr, input bit v, input int pc, input int ins);
    vecs.push_back('{seg: seg, rdy: rdy, redir: redir, rpc: rpc,
                     req: req, addr: addr, v: v, pc: pc, ins: ins});
  endtask

  task automatic run_seg(input int seg);
    int c;
    c = 0;
    foreach (vecs[i]) begin
      if (vecs[i].seg == seg) begin
        dec_ready   = vecs[i].rdy;
        redirect    = vecs[i].redir;
        redirect_pc = ADDR_W'(vecs[i].rpc);
        #2;
        chk($sformatf("seg%0d c%0d imem_req", seg, c),  32'(imem_req),  32'(vecs[i].req));
        chk($sformatf("seg%0d c%0d imem_addr", seg, c), 32'(imem_addr), 32'(vecs[i].addr));
        chk($sformatf("seg%0d c%0d dec_valid", seg, c), 32'(dec_valid), 32'(vecs[i].v));
        if (vecs[i].v) begin
          chk($sformatf("seg%0d c%0d dec_pc", seg, c),    32'(dec_pc),    32'(vecs[i].pc));
          chk($sformatf("seg%0d c%0d dec_instr", seg, c), 32'(dec_instr), 32'(vecs[i].ins));
        end
        tick();
        c++;
      end
    end
    redirect    = 1'b0;
    redirect_pc = '0;
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for clk
  task automatic mid_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    chk_reset(tag);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dec_ready   = 1'b0;
    pend.delete();
    mout = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst         = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;

    // seg, rdy, redir, rpc, req, addr, v, pc, ins
    // 1: streaming, 1-cycle memory
    add(1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 2, 1, 0, 100);
    add(1, 1, 0, 0, 1, 3, 1, 1, 101);
    add(1, 1, 0, 0, 1, 4, 1, 2, 102);
    add(1, 1, 0, 0, 1, 5, 1, 3, 103);
    add(1, 1, 0, 0, 1, 6, 1, 4, 104);
    add(1, 1, 0, 0, 1, 7, 1, 5, 105);
    // 2: backpressure then release, 1-cycle memory
    add(2, 0, 0, 0, 1, 0, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0, 0, 0);
    add(2, 0, 0, 0, 1, 2, 1, 0, 100);
    add(2, 0, 0, 0, 1, 3, 1, 0, 100);
    add(2, 0, 0, 0, 0, 4, 1, 0, 100);
    add(2, 0, 0, 0, 0, 4, 1, 0, 100);
    add(2, 0, 0, 0, 0, 4, 1, 0, 100);
    add(2, 1, 0, 0, 0, 4, 1, 0, 100);
    add(2, 1, 0, 0, 1, 4, 1, 1, 101);
    add(2, 1, 0, 0, 1, 5, 1, 2, 102);
    add(2, 1, 0, 0, 1, 6, 1, 3, 103);
    add(2, 1, 0, 0, 1, 7, 1, 4, 104);
    // 3: redirect to 16 with two stale responses, 2-cycle memory
    add(3, 1, 0, 0,  1, 0,  0, 0,  0);
    add(3, 1, 0, 0,  1, 1,  0, 0,  0);
    add(3, 1, 1, 16, 0, 2,  0, 0,  0);
    add(3, 1, 0, 0,  1, 16, 0, 0,  0);
    add(3, 1, 0, 0,  1, 17, 0, 0,  0);
    add(3, 1, 0, 0,  0, 18, 0, 0,  0);
    add(3, 1, 0, 0,  1, 18, 1, 16, 116);
    add(3, 1, 0, 0,  1, 19, 1, 17, 117);
    // 4: redirect to 30, address wrap, 1-cycle memory
    add(4, 1, 0, 0,  1, 0,  0, 0,  0);
    add(4, 1, 1, 30, 0, 1,  0, 0,  0);
    add(4, 1, 0, 0,  1, 30, 0, 0,  0);
    add(4, 1, 0, 0,  1, 31, 0, 0,  0);
    add(4, 1, 0, 0,  1, 0,  1, 30, 130);
    add(4, 1, 0, 0,  1, 1,  1, 31, 131);
    add(4, 1, 0, 0,  1, 2,  1, 0,  100);
    add(4, 1, 0, 0,  1, 3,  1, 1,  101);
    // 5: redirect coinciding with rvalid and a decode pop, 2-cycle memory
    add(5, 1, 0, 0, 1, 0,  0, 0, 0);
    add(5, 1, 0, 0, 1, 1,  0, 0, 0);
    add(5, 1, 0, 0, 0, 2,  0, 0, 0);
    add(5, 1, 1, 8, 0, 2,  1, 0, 100);
    add(5, 1, 0, 0, 1, 8,  0, 0, 0);
    add(5, 1, 0, 0, 1, 9,  0, 0, 0);
    add(5, 1, 0, 0, 0, 10, 0, 0, 0);
    add(5, 1, 0, 0, 1, 10, 1, 8, 108);

    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b1;
    cyc = 0;
    #1;
    chk("por_release imem_req",  32'(imem_req),  32'd1);
    chk("por_release imem_addr", 32'(imem_addr), 32'd0);

    lat = 1;
    run_seg(1);
    mid_reset("reset_after_stream");
    lat = 1;
    run_seg(2);
    mid_reset("reset_after_backpressure");
    lat = 2;
    run_seg(3);
    mid_reset("reset_after_redirect");
    lat = 1;
    run_seg(4);
    mid_reset("reset_after_wrap");
    lat = 2;
    run_seg(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
